// File: rtl/id_token_scanner.sv
// rtl/id_token_scanner.sv - per-char letter-led identifier digit flagging with token
// delimiting, length/validity reporting and a saturating valid-token count.
module id_token_scanner #(
  parameter int LEN_W            = 4,
  parameter int CNT_W            = 8,
  parameter int MIN_DIGITS       = 1,
  parameter bit ALLOW_UNDERSCORE = 1'b1,
  parameter bit STRICT           = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       char,
  input  logic             flush,
  output logic             out_valid,
  output logic             match,
  output logic             tok_done,
  output logic             tok_ok,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_cnt
);

  localparam logic [LEN_W-1:0] LMAX  = '1;
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [LEN_W-1:0] MIN_D = LEN_W'(MIN_DIGITS);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ALPHA,
    DIGIT,
    REJ,
    OVF
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] dig;
  logic             is_l;
  logic             is_d;
  logic             ok_now;

  always_comb begin
    is_d   = (char >= 8'h30) && (char <= 8'h39);
    is_l   = ((char >= 8'h41) && (char <= 8'h5A)) ||
             ((char >= 8'h61) && (char <= 8'h7A)) ||
             (ALLOW_UNDERSCORE && (char == 8'h5F));
    ok_now = (state == DIGIT) && (dig >= MIN_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      dig       <= '0;
      out_valid <= 1'b0;
      match     <= 1'b0;
      tok_done  <= 1'b0;
      tok_ok    <= 1'b0;
      tok_len   <= '0;
      tok_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      match     <= 1'b0;
      tok_done  <= 1'b0;
      if (flush) begin
        state <= IDLE;
        len   <= '0;
        dig   <= '0;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        unique case (state)
          IDLE: begin
            if (is_l) begin
              state <= ALPHA;
              len   <= ONE;
              dig   <= '0;
            end else if (is_d && STRICT) begin
              state <= REJ;
              len   <= ONE;
              dig   <= '0;
            end
          end
          ALPHA, DIGIT: begin
            if (is_l || is_d) begin
              // A char beyond LMAX poisons the token; len stays pinned at LMAX.
              if (len == LMAX) begin
                state <= OVF;
              end else begin
                len <= len + 1'b1;
                if (is_l) begin
                  state <= ALPHA;
                  dig   <= '0;
                end else begin
                  state <= DIGIT;
                  match <= 1'b1;
                  if (dig != LMAX) dig <= dig + 1'b1;
                end
              end
            end else begin
              tok_done <= 1'b1;
              tok_ok   <= ok_now;
              tok_len  <= len;
              state    <= IDLE;
              len      <= '0;
              dig      <= '0;
              if (ok_now && (tok_cnt != CMAX)) tok_cnt <= tok_cnt + 1'b1;
            end
          end
          REJ: begin
            if (is_l || is_d) begin
              if (len == LMAX) state <= OVF;
              else len <= len + 1'b1;
            end else begin
              tok_done <= 1'b1;
              tok_ok   <= 1'b0;
              tok_len  <= len;
              state    <= IDLE;
              len      <= '0;
              dig      <= '0;
            end
          end
          OVF: begin
            if (!(is_l || is_d)) begin
              tok_done <= 1'b1;
              tok_ok   <= 1'b0;
              tok_len  <= LMAX;
              state    <= IDLE;
              len      <= '0;
              dig      <= '0;
            end
          end
          default: begin
            state <= IDLE;
            len   <= '0;
            dig   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_token_scanner.sv
// tb/tb_id_token_scanner.sv - directed and randomized bench for id_token_scanner
// across four parameter sets, checked against a token-string model.
module tb_id_token_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       flush;
  logic [7:0] ch;

  always #5 clk = ~clk;

  logic       ov0, mt0, td0, tk0, ov1, mt1, td1, tk1, ov2, mt2, td2, tk2, ov3, mt3, td3, tk3;
  logic [3:0] tl0, tl1, tl2;
  logic [2:0] tl3;
  logic [7:0] tc0, tc1, tc2;
  logic [1:0] tc3;

  logic [3:0] ov, mt, td, tk;
  logic [3:0] tl [4];
  logic [7:0] tc [4];

  always_comb begin
    ov = {ov3, ov2, ov1, ov0};
    mt = {mt3, mt2, mt1, mt0};
    td = {td3, td2, td1, td0};
    tk = {tk3, tk2, tk1, tk0};
    tl[0] = tl0; tl[1] = tl1; tl[2] = tl2; tl[3] = {1'b0, tl3};
    tc[0] = tc0; tc[1] = tc1; tc[2] = tc2; tc[3] = {6'b0, tc3};
  end

  id_token_scanner u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush),
    .out_valid(ov0), .match(mt0), .tok_done(td0), .tok_ok(tk0), .tok_len(tl0), .tok_cnt(tc0));

  id_token_scanner #(.STRICT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush),
    .out_valid(ov1), .match(mt1), .tok_done(td1), .tok_ok(tk1), .tok_len(tl1), .tok_cnt(tc1));

  id_token_scanner #(.ALLOW_UNDERSCORE(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush),
    .out_valid(ov2), .match(mt2), .tok_done(td2), .tok_ok(tk2), .tok_len(tl2), .tok_cnt(tc2));

  id_token_scanner #(.LEN_W(3), .CNT_W(2), .MIN_DIGITS(2), .ALLOW_UNDERSCORE(1'b0), .STRICT(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush),
    .out_valid(ov3), .match(mt3), .tok_done(td3), .tok_ok(tk3), .tok_len(tl3), .tok_cnt(tc3));

  int cfg_lmax   [4] = '{15, 15, 15, 7};
  int cfg_cmax   [4] = '{255, 255, 255, 3};
  int cfg_min    [4] = '{1, 1, 1, 2};
  bit cfg_us     [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit cfg_strict [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Model: the token is kept as the literal string of its chars.
  bit         m_in  [4];
  int         m_n   [4];
  logic [7:0] m_buf [4][64];
  bit         e_ov [4], e_mt [4], e_td [4], e_tk [4];
  int         e_tl [4], e_tc [4];

  int n_run  = 0;
  int n_fail = 0;

  function automatic bit is_letter(logic [7:0] c, bit us);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (us && (c == 8'h5F));
  endfunction

  function automatic bit is_digit(logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_in[k] = 0; m_n[k] = 0;
      e_ov[k] = 0; e_mt[k] = 0; e_td[k] = 0; e_tk[k] = 0; e_tl[k] = 0; e_tc[k] = 0;
    end
  endtask

  task automatic model_step(bit v, logic [7:0] c, bit f);
    int trail;
    for (int k = 0; k < 4; k++) begin
      e_ov[k] = 0; e_mt[k] = 0; e_td[k] = 0;
      if (f) begin
        m_in[k] = 0; m_n[k] = 0;
      end else if (v) begin
        e_ov[k] = 1;
        if (is_letter(c, cfg_us[k]) || is_digit(c)) begin
          if (!m_in[k] && (is_letter(c, cfg_us[k]) || cfg_strict[k])) begin
            m_in[k] = 1; m_n[k] = 0;
          end
          if (m_in[k]) begin
            if (m_n[k] < 64) m_buf[k][m_n[k]] = c;
            m_n[k]++;
            e_mt[k] = is_digit(c) && is_letter(m_buf[k][0], cfg_us[k]) && (m_n[k] <= cfg_lmax[k]);
          end
        end else if (m_in[k]) begin
          e_td[k] = 1;
          e_tl[k] = (m_n[k] > cfg_lmax[k]) ? cfg_lmax[k] : m_n[k];
          trail = 0;
          if (m_n[k] <= cfg_lmax[k])
            for (int i = m_n[k] - 1; i >= 0 && is_digit(m_buf[k][i]); i--) trail++;
          e_tk[k] = (m_n[k] <= cfg_lmax[k]) && is_letter(m_buf[k][0], cfg_us[k]) && (trail >= cfg_min[k]);
          if (e_tk[k] && (e_tc[k] < cfg_cmax[k])) e_tc[k]++;
          m_in[k] = 0; m_n[k] = 0;
        end
      end
    end
  endtask

  task automatic send(bit v, logic [7:0] c, bit f);
    @(negedge clk);
    in_valid = v; ch = c; flush = f;
    @(posedge clk);
    model_step(v, c, f);
    #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, s[i], 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; flush = 0; ch = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if ({ov[k], mt[k], td[k], tk[k], tl[k], tc[k]} !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs u%0d: got ov=%b mt=%b td=%b tk=%b tl=%0d tc=%0d want all 0",
                 k, ov[k], mt[k], td[k], tk[k], tl[k], tc[k]);
      end
    end
  endtask

  task automatic test_basic();
    string    s = "ab12 ";
    bit [4:0] em = 5'b01100;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, s[i], 1'b0);
      n_run++;
      if (mt[0] !== em[i]) begin n_fail++; $display("FAIL basic_match[%0d]: got %b want %b", i, mt[0], em[i]); end
      n_run++;
      if ({ov[0], td[0]} !== {1'b1, i == 4}) begin
        n_fail++; $display("FAIL basic_ov_td[%0d]: got %b%b want 1%b", i, ov[0], td[0], i == 4);
      end
    end
    n_run++;
    if ({tk[0], tl[0]} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL basic_tok: got ok=%b len=%0d want ok=1 len=4", tk[0], tl[0]); end
    send(1'b0, 8'h00, 1'b0);
    n_run++;
    if (tc[0] !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", tc[0]); end
  endtask

  task automatic test_mixed();
    string    s = "a1b2;";
    bit [4:0] em = 5'b01010;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, s[i], 1'b0);
      n_run++;
      if (mt[0] !== em[i]) begin n_fail++; $display("FAIL mixed_match[%0d]: got %b want %b", i, mt[0], em[i]); end
    end
    n_run++;
    if ({td[0], tk[0], tl[0]} !== {2'b11, 4'd4}) begin
      n_fail++; $display("FAIL mixed_tok1: got done=%b ok=%b len=%0d want 1 1 4", td[0], tk[0], tl[0]);
    end
    send_str("abc;");
    n_run++;
    if ({td[0], tk[0], tl[0], tc[0]} !== {2'b10, 4'd3, 8'd1}) begin
      n_fail++; $display("FAIL mixed_tok2: got done=%b ok=%b len=%0d cnt=%0d want 1 0 3 1", td[0], tk[0], tl[0], tc[0]);
    end
  endtask

  task automatic test_strict();
    string    s = "9a1 ";
    bit [3:0] em0 = 4'b0100;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, s[i], 1'b0);
      n_run++;
      if ({mt[1], mt[0]} !== {1'b0, em0[i]}) begin
        n_fail++; $display("FAIL strict_match[%0d]: got s1=%b s0=%b want 0 %b", i, mt[1], mt[0], em0[i]);
      end
    end
    n_run++;
    if ({td[1], tk[1], tl[1]} !== {2'b10, 4'd3}) begin
      n_fail++; $display("FAIL strict1_tok: got done=%b ok=%b len=%0d want 1 0 3", td[1], tk[1], tl[1]);
    end
    n_run++;
    if ({td[0], tk[0], tl[0]} !== {2'b11, 4'd2}) begin
      n_fail++; $display("FAIL strict0_tok: got done=%b ok=%b len=%0d want 1 1 2", td[0], tk[0], tl[0]);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    send(1'b1, "a", 1'b0);
    for (int i = 1; i <= 15; i++) begin
      send(1'b1, "1", 1'b0);
      n_run++;
      if ({mt[0], mt[3]} !== {i <= 14, i <= 6}) begin
        n_fail++; $display("FAIL ovf_match[%0d]: got u0=%b u3=%b want %b %b", i, mt[0], mt[3], i <= 14, i <= 6);
      end
    end
    send(1'b1, " ", 1'b0);
    n_run++;
    if ({td[0], tk[0], tl[0], td[3], tk[3], tl[3]} !== {2'b10, 4'd15, 2'b10, 4'd7}) begin
      n_fail++; $display("FAIL ovf_tok: got u0 %b%b len=%0d u3 %b%b len=%0d want 10/15 10/7",
                         td[0], tk[0], tl[0], td[3], tk[3], tl[3]);
    end
    send(1'b1, "a", 1'b0);
    for (int i = 0; i < 14; i++) send(1'b1, "1", 1'b0);
    send(1'b1, " ", 1'b0);
    n_run++;
    if ({td[0], tk[0], tl[0]} !== {2'b11, 4'd15}) begin
      n_fail++; $display("FAIL lmax_exact_tok: got done=%b ok=%b len=%0d want 1 1 15", td[0], tk[0], tl[0]);
    end
  endtask

  task automatic test_underscore();
    string s = "x_7 ";
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, s[i], 1'b0);
      n_run++;
      if ({td[0], td[2]} !== {i == 3, i == 1}) begin
        n_fail++; $display("FAIL us_done[%0d]: got u0=%b u2=%b want %b %b", i, td[0], td[2], i == 3, i == 1);
      end
      if (i == 1) begin
        n_run++;
        if ({tk[2], tl[2]} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL us0_tok: got ok=%b len=%0d want 0 1", tk[2], tl[2]); end
      end
      if (i == 2) begin
        n_run++;
        if ({mt[0], mt[2]} !== 2'b10) begin n_fail++; $display("FAIL us_match7: got u0=%b u2=%b want 1 0", mt[0], mt[2]); end
      end
    end
    n_run++;
    if ({tk[0], tl[0]} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL us1_tok: got ok=%b len=%0d want 1 3", tk[0], tl[0]); end
  endtask

  task automatic test_flush();
    apply_reset();
    send_str("a1 ");
    send_str("ab1");
    send(1'b1, " ", 1'b1);
    n_run++;
    if ({ov[0], mt[0], td[0], tc[0]} !== {3'b000, 8'd1}) begin
      n_fail++; $display("FAIL flush_cycle: got ov=%b mt=%b td=%b cnt=%0d want 0 0 0 1", ov[0], mt[0], td[0], tc[0]);
    end
    send(1'b1, " ", 1'b0);
    n_run++;
    if ({ov[0], td[0], tc[0]} !== {2'b10, 8'd1}) begin
      n_fail++; $display("FAIL flush_after: got ov=%b td=%b cnt=%0d want 1 0 1", ov[0], td[0], tc[0]);
    end
  endtask

  task automatic test_gaps();
    string    s = "ab12 ";
    bit [4:0] em = 5'b01100;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, "9", 1'b0);
      n_run++;
      if ({ov[0], mt[0], td[0]} !== 3'b000) begin
        n_fail++; $display("FAIL gap_idle[%0d]: got ov=%b mt=%b td=%b want 000", i, ov[0], mt[0], td[0]);
      end
      send(1'b1, s[i], 1'b0);
      n_run++;
      if ({mt[0], td[0]} !== {em[i], i == 4}) begin
        n_fail++; $display("FAIL gap_char[%0d]: got mt=%b td=%b want %b %b", i, mt[0], td[0], em[i], i == 4);
      end
    end
    send(1'b0, " ", 1'b0);
    n_run++;
    if ({td[0], tk[0], tl[0], tc[0]} !== {2'b01, 4'd4, 8'd1}) begin
      n_fail++; $display("FAIL gap_hold: got td=%b ok=%b len=%0d cnt=%0d want 0 1 4 1", td[0], tk[0], tl[0], tc[0]);
    end
  endtask

  task automatic test_min_cnt_sat();
    apply_reset();
    send_str("ab1 ");
    n_run++;
    if ({td[3], tk[3], tl[3]} !== {2'b10, 4'd3}) begin
      n_fail++; $display("FAIL min2_short: got done=%b ok=%b len=%0d want 1 0 3", td[3], tk[3], tl[3]);
    end
    send_str("ab12 ");
    n_run++;
    if ({td[3], tk[3], tl[3]} !== {2'b11, 4'd4}) begin
      n_fail++; $display("FAIL min2_ok: got done=%b ok=%b len=%0d want 1 1 4", td[3], tk[3], tl[3]);
    end
    for (int i = 0; i < 4; i++) send_str("a12 ");
    n_run++;
    if ({tc[3], tc[0]} !== {8'd3, 8'd6}) begin
      n_fail++; $display("FAIL cnt_sat: got u3=%0d u0=%0d want 3 6", tc[3], tc[0]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_str("a1 ");
    send_str("ab1");
    #2;
    rst_n = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_run++;
      if ({ov[k], mt[k], td[k], tk[k], tl[k], tc[k]} !== 16'h0) begin
        n_fail++;
        $display("FAIL async_reset u%0d: got ov=%b mt=%b td=%b tk=%b tl=%0d tc=%0d want all 0",
                 k, ov[k], mt[k], td[k], tk[k], tl[k], tc[k]);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    send(1'b1, " ", 1'b0);
    n_run++;
    if (td[0] !== 1'b0) begin n_fail++; $display("FAIL async_reset_nodone: got %b want 0", td[0]); end
  endtask

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 99);
    if (r < 20) return 8'(8'h41 + $urandom_range(0, 25));
    if (r < 38) return 8'(8'h61 + $urandom_range(0, 25));
    if (r < 72) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 78) return 8'h5F;
    if (r < 88) return 8'h20;
    case ($urandom_range(0, 7))
      0: return 8'h2F;
      1: return 8'h3A;
      2: return 8'h40;
      3: return 8'h5B;
      4: return 8'h60;
      5: return 8'h7B;
      6: return 8'h3B;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    int r;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      send(r >= 12, rand_char(), r < 3);
      for (int k = 0; k < 4; k++) begin
        n_run++;
        if ({ov[k], mt[k], td[k], tk[k], tl[k], tc[k]} !==
            {e_ov[k], e_mt[k], e_td[k], e_tk[k], 4'(e_tl[k]), 8'(e_tc[k])}) begin
          n_fail++;
          $display("FAIL random cyc%0d u%0d: got ov=%b mt=%b td=%b tk=%b tl=%0d tc=%0d want %b %b %b %b %0d %0d",
                   cyc, k, ov[k], mt[k], td[k], tk[k], tl[k], tc[k],
                   e_ov[k], e_mt[k], e_td[k], e_tk[k], e_tl[k], e_tc[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; ch = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_mixed();
    test_strict();
    test_overflow();
    test_underscore();
    test_flush();
    test_gaps();
    test_min_cnt_sat();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
